game_grid_dbuf_avl: RTL and testbench

Parametrised Avalon-MM slave that holds a ROWS×COLS game tile grid in two banks, a back bank written by software and a front bank read by the pixel mapper. It is the next-generation grid register file for the game VGA path. Software requests a swap, and the banks flip at the start of the next vertical sync, so a frame never shows a half-updated grid. An optional copy pass after each flip reloads the back bank from the newly displayed bank.

---
 rtl/game_grid_dbuf_avl.sv | 157 +++++++++++++++
 tb/tb_game_grid_dbuf_avl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/game_grid_dbuf_avl.sv
// rtl/game_grid_dbuf_avl.sv - double-buffered game tile grid with Avalon-MM access and vsync-aligned bank swap
// Optional macro GRID_COPY_ON_SWAP_EN adds a post-flip copy pass from the displayed bank into the back bank.
module game_grid_dbuf_avl #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int CELL_BITS = 16,
    parameter int ADDR_W    = 5
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      AVL_READ,
    input  logic                      AVL_WRITE,
    input  logic                      AVL_CS,
    input  logic [ADDR_W-1:0]         AVL_ADDR,
    input  logic [15:0]               AVL_WRITEDATA,
    output logic [15:0]               AVL_READDATA,
    output logic                      AVL_WAITREQUEST,
    input  logic                      VS,
    input  logic [$clog2(ROWS)-1:0]   DISP_ROW,
    input  logic [$clog2(COLS)-1:0]   DISP_COL,
    output logic [CELL_BITS-1:0]      DISP_CELL
);

    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(N + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_COPY = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   bank_sel_q;
    logic                   vs_q;
    logic [7:0]             frame_q;
    logic [15:0]            readdata_q, readdata_d;
    logic [CELL_BITS-1:0]   disp_q, disp_d;
    logic [CELL_BITS-1:0]   bank0_q [N];
    logic [CELL_BITS-1:0]   bank1_q [N];

    logic                   pending, copy_busy;
    logic                   acc, wr_en, rd_en, cell_wr, swap_wr;
    logic                   vs_fall, flip;
    logic [IW-1:0]          av_idx, disp_idx;
    logic                   disp_ok;
    logic [CELL_BITS-1:0]   back_rd, front_disp;

    assign acc     = AVL_CS & ~AVL_WAITREQUEST;
    assign wr_en   = acc & AVL_WRITE;
    assign rd_en   = acc & AVL_READ;
    assign av_idx  = AVL_ADDR[IW-1:0];
    assign cell_wr = wr_en & (AVL_ADDR < CTRL_A);
    assign swap_wr = wr_en & (AVL_ADDR == CTRL_A) & AVL_WRITEDATA[0];
    assign vs_fall = vs_q & ~VS;
    assign flip    = (state_q == ST_PEND) & vs_fall;

    // bank_sel selects the front bank; the back bank is always the other one.
    assign back_rd    = bank_sel_q ? bank0_q[av_idx] : bank1_q[av_idx];
    assign disp_idx   = IW'(DISP_ROW) * IW'(COLS) + IW'(DISP_COL);
    assign disp_ok    = (32'(DISP_ROW) < ROWS) && (32'(DISP_COL) < COLS);
    assign front_disp = bank_sel_q ? bank1_q[disp_idx] : bank0_q[disp_idx];

`ifdef GRID_COPY_ON_SWAP_EN
    logic [IW-1:0] copy_idx_q, copy_idx_d;

    assign copy_idx_d = (state_q == ST_COPY) ? copy_idx_q + 1'b1 : '0;

    always_ff @(posedge CLK) begin
        if (RESET) copy_idx_q <= '0;
        else       copy_idx_q <= copy_idx_d;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (swap_wr) state_d = ST_PEND;
`ifdef GRID_COPY_ON_SWAP_EN
            ST_PEND: if (vs_fall) state_d = ST_COPY;
            ST_COPY: if (copy_idx_q == IW'(N - 1)) state_d = ST_IDLE;
`else
            ST_PEND: if (vs_fall) state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pending = (state_q == ST_PEND);
`ifdef GRID_COPY_ON_SWAP_EN
        copy_busy = (state_q == ST_COPY);
`else
        copy_busy = 1'b0;
`endif
        AVL_WAITREQUEST = copy_busy;
    end

    always_comb begin
        readdata_d = readdata_q;
        if (rd_en) begin
            if (AVL_ADDR < CTRL_A)       readdata_d = 16'(back_rd);
            else if (AVL_ADDR == CTRL_A) readdata_d = {15'd0, pending};
            else if (AVL_ADDR == STAT_A) readdata_d = {frame_q, 6'd0, copy_busy, pending};
            else                         readdata_d = 16'd0;
        end
        disp_d = disp_ok ? front_disp : '0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bank_sel_q <= 1'b0;
            vs_q       <= 1'b1;
            frame_q    <= 8'd0;
            readdata_q <= 16'd0;
            disp_q     <= '0;
        end else begin
            vs_q       <= VS;
            readdata_q <= readdata_d;
            disp_q     <= disp_d;
            if (vs_fall) frame_q <= frame_q + 8'd1;
            if (flip)    bank_sel_q <= ~bank_sel_q;
        end
    end

    // A write in the flip cycle uses the pre-flip select, so it lands in the bank about to be shown.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < N; i++) begin
                bank0_q[i] <= '0;
                bank1_q[i] <= '0;
            end
        end else begin
            if (cell_wr) begin
                if (bank_sel_q) bank0_q[av_idx] <= AVL_WRITEDATA[CELL_BITS-1:0];
                else            bank1_q[av_idx] <= AVL_WRITEDATA[CELL_BITS-1:0];
            end
`ifdef GRID_COPY_ON_SWAP_EN
            if (state_q == ST_COPY) begin
                if (bank_sel_q) bank0_q[copy_idx_q] <= bank1_q[copy_idx_q];
                else            bank1_q[copy_idx_q] <= bank0_q[copy_idx_q];
            end
`endif
        end
    end

    assign AVL_READDATA = readdata_q;
    assign DISP_CELL    = disp_q;

endmodule

// File: tb/tb_game_grid_dbuf_avl.sv
// tb/tb_game_grid_dbuf_avl.sv - directed self-checking bench for game_grid_dbuf_avl
module tb_game_grid_dbuf_avl;

    logic        clk = 1'b0;
    logic        reset;
    logic        avl_read, avl_write, avl_cs;
    logic [4:0]  avl_addr;
    logic [15:0] avl_writedata;
    logic [15:0] avl_readdata;
    logic        avl_waitrequest;
    logic        vs;
    logic [1:0]  disp_row, disp_col;
    logic [15:0] disp_cell;

    int total = 0;
    int bad   = 0;

`ifdef GRID_COPY_ON_SWAP_EN
    localparam bit COPY_EN = 1'b1;
`else
    localparam bit COPY_EN = 1'b0;
`endif

    game_grid_dbuf_avl dut (
        .CLK             (clk),
        .RESET           (reset),
        .AVL_READ        (avl_read),
        .AVL_WRITE       (avl_write),
        .AVL_CS          (avl_cs),
        .AVL_ADDR        (avl_addr),
        .AVL_WRITEDATA   (avl_writedata),
        .AVL_READDATA    (avl_readdata),
        .AVL_WAITREQUEST (avl_waitrequest),
        .VS              (vs),
        .DISP_ROW        (disp_row),
        .DISP_COL        (disp_col),
        .DISP_CELL       (disp_cell)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int g = 0;
        while (avl_waitrequest !== 1'b0 && g < 100) begin
            tick();
            g++;
        end
        chk("wait_bound", 16'(g < 100), 16'd1);
    endtask

    task automatic avl_wr(input logic [4:0] a, input logic [15:0] d);
        avl_cs = 1'b1; avl_write = 1'b1; avl_addr = a; avl_writedata = d;
        wait_ready();
        tick();
        avl_cs = 1'b0; avl_write = 1'b0;
    endtask

    task automatic avl_rd(input logic [4:0] a, output logic [15:0] d);
        avl_cs = 1'b1; avl_read = 1'b1; avl_addr = a;
        wait_ready();
        tick();
        avl_cs = 1'b0; avl_read = 1'b0;
        d = avl_readdata;
    endtask

    task automatic pulse_vs();
        vs = 1'b0;
        tick();
        vs = 1'b1;
        tick();
    endtask

    initial begin
        logic [15:0] r, disp1;
        int cnt, g;

        reset = 1'b1; avl_read = 1'b0; avl_write = 1'b0; avl_cs = 1'b0;
        avl_addr = '0; avl_writedata = '0; vs = 1'b1; disp_row = '0; disp_col = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_waitreq", 16'(avl_waitrequest), 16'd0);
        chk("rst_readdata", avl_readdata, 16'h0000);
        chk("rst_disp", disp_cell, 16'h0000);
        avl_rd(5'd17, r); chk("rst_status", r, 16'h0000);
        avl_rd(5'd0, r);  chk("rst_cell0", r, 16'h0000);
        avl_rd(5'd16, r); chk("rst_ctrl", r, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            disp_row = 2'(i / 4); disp_col = 2'(i % 4);
            tick();
            chk($sformatf("rst_disp_%0d", i), disp_cell, 16'h0000);
        end

        // Back-bank write is invisible to the display until a swap.
        avl_wr(5'd5, 16'h00AB);
        disp_row = 2'd1; disp_col = 2'd1;
        tick();
        chk("noswap_disp", disp_cell, 16'h0000);
        avl_rd(5'd5, r); chk("noswap_rd5", r, 16'h00AB);

        avl_wr(5'd5, 16'h1234);
        avl_wr(5'd16, 16'h0001);
        avl_rd(5'd16, r); chk("pend_ctrl", r, 16'h0001);
        avl_rd(5'd17, r); chk("pend_status", r, 16'h0001);
        vs = 1'b0;
        tick();
        vs = 1'b1;
        avl_cs = 1'b1; avl_read = 1'b1; avl_addr = 5'd5;
        cnt = 0; g = 0; disp1 = 16'hFFFF;
        while (avl_waitrequest === 1'b1 && g < 40) begin
            cnt++;
            tick();
            g++;
            if (g == 1) disp1 = disp_cell;
        end
        tick();
        if (g == 0) disp1 = disp_cell;
        avl_cs = 1'b0; avl_read = 1'b0;
        r = avl_readdata;
        chk("copy_wait_cycles", 16'(cnt), COPY_EN ? 16'd16 : 16'd0);
        chk("flip_disp", disp1, 16'h1234);
        chk("post_flip_rd5", r, COPY_EN ? 16'h1234 : 16'h0000);
        avl_rd(5'd17, r); chk("flip_status", r, 16'h0100);

        // Swap request coinciding with vs_fall must wait for the next vs_fall.
        vs = 1'b0; avl_cs = 1'b1; avl_write = 1'b1; avl_addr = 5'd16; avl_writedata = 16'h0001;
        tick();
        vs = 1'b1; avl_cs = 1'b0; avl_write = 1'b0;
        avl_rd(5'd16, r); chk("same_edge_ctrl", r, 16'h0001);
        avl_rd(5'd17, r); chk("same_edge_status", r, 16'h0201);
        chk("same_edge_disp", disp_cell, 16'h1234);
        avl_wr(5'd5, 16'h5555);
        pulse_vs();
        avl_rd(5'd17, r); chk("second_flip_status", r, 16'h0300);
        chk("second_flip_disp", disp_cell, 16'h5555);
        avl_rd(5'd5, r); chk("second_flip_rd5", r, COPY_EN ? 16'h5555 : 16'h1234);

        // Reset in the third cycle after the flip (third COPY cycle when copy is built).
        avl_wr(5'd16, 16'h0001);
        vs = 1'b0;
        tick();
        vs = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_waitreq", 16'(avl_waitrequest), 16'd0);
        chk("abort_readdata", avl_readdata, 16'h0000);
        chk("abort_disp", disp_cell, 16'h0000);
        avl_rd(5'd17, r); chk("abort_status", r, 16'h0000);
        avl_rd(5'd16, r); chk("abort_ctrl", r, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            avl_rd(5'(i), r);
            chk($sformatf("abort_cell_%0d", i), r, 16'h0000);
        end

        // Writes above the register map and to STATUS are dropped.
        avl_wr(5'd20, 16'hFFFF);
        avl_wr(5'd17, 16'hFFFF);
        avl_rd(5'd20, r); chk("oor_rd20", r, 16'h0000);
        avl_rd(5'd4, r);  chk("oor_alias_cell4", r, 16'h0000);
        avl_rd(5'd17, r); chk("status_ro", r, 16'h0000);

        for (int i = 0; i < 300; i++) pulse_vs();
        avl_rd(5'd17, r); chk("frame_wrap", r, 16'h2C00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
